// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared FSM state type, lane count and address helpers for the memory responder.
package riscv_mem_pkg;
    localparam int WORD_BITS = 32;
    localparam int BYTE_LANES = WORD_BITS / 8;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    function automatic logic in_range(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction
endpackage

// File: rtl/riscv_mem_responder_if.sv
// riscv_mem_responder_if: preload, instruction-fetch and data-port signals between core side and memory.
interface riscv_mem_responder_if #(parameter int DW = 32) ();
    logic ld_we;
    logic [31:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic i_req;
    logic [31:0] i_addr;
    logic i_valid;
    logic [DW-1:0] i_rdata;
    logic d_req;
    logic d_we;
    logic [DW/8-1:0] d_be;
    logic [31:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic d_gnt;
    logic d_rvalid;
    logic [DW-1:0] d_rdata;
    logic d_err;
    modport master (
        output ld_we, ld_addr, ld_data, i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input i_valid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err
    );
    modport slave (
        input ld_we, ld_addr, ld_data, i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output i_valid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err
    );
endinterface

// File: rtl/riscv_mem_array.sv
// riscv_mem_array: word storage with one byte-enabled write port (preload beats store) and two
// registered read ports that return the pre-write contents on a same-cycle collision.
module riscv_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    ld_we_i,
    input  logic [ADDR_WIDTH-1:0]   ld_idx_i,
    input  logic [DATA_WIDTH-1:0]   ld_data_i,
    input  logic                    st_we_i,
    input  logic [ADDR_WIDTH-1:0]   st_idx_i,
    input  logic [DATA_WIDTH/8-1:0] st_be_i,
    input  logic [DATA_WIDTH-1:0]   st_data_i,
    input  logic                    i_re_i,
    input  logic [ADDR_WIDTH-1:0]   i_idx_i,
    output logic [DATA_WIDTH-1:0]   i_rdata_o,
    input  logic [ADDR_WIDTH-1:0]   d_idx_i,
    output logic [DATA_WIDTH-1:0]   d_rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;
    always_ff @(posedge clk) begin
        if (ld_we_i) mem_q[ld_idx_i] <= ld_data_i;
        else if (st_we_i)
            for (int b = 0; b < DATA_WIDTH / 8; b++)
                if (st_be_i[b]) mem_q[st_idx_i][8*b +: 8] <= st_data_i[8*b +: 8];
        if (i_re_i) i_rdata_q <= mem_q[i_idx_i];
        d_rdata_q <= mem_q[d_idx_i];
    end
    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;
endmodule

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: 1-cycle instruction port plus handshaked data port with WAIT_STATES latency.
// Define MEM_ALIGN_CHECK_EN to reject misaligned data/instruction addresses.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input logic clk,
    input logic reset,
    riscv_mem_responder_if.slave mem_if
);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    state_t state_q;
    logic [3:0] cnt_q;
    logic gnt_q, rvalid_q, err_q, bad_q, we_q, i_valid_q, i_ok_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q, i_word, d_word;
    logic d_ok, i_ok, st_we, accept;
`ifdef MEM_ALIGN_CHECK_EN
    assign d_ok = in_range(mem_if.d_addr, ADDR_WIDTH) && mem_if.d_addr[1:0] == 2'b00;
    assign i_ok = in_range(mem_if.i_addr, ADDR_WIDTH) && mem_if.i_addr[1:0] == 2'b00;
`else
    assign d_ok = in_range(mem_if.d_addr, ADDR_WIDTH);
    assign i_ok = in_range(mem_if.i_addr, ADDR_WIDTH);
`endif
    assign accept = mem_if.d_req && gnt_q;
    // Store commits in the response cycle; a reset landing on that edge still drops it.
    assign st_we = rvalid_q && we_q && !err_q && !reset;
    riscv_mem_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clk       (clk),
        .ld_we_i   (mem_if.ld_we && in_range(mem_if.ld_addr, ADDR_WIDTH)),
        .ld_idx_i  (ADDR_WIDTH'(word_index(mem_if.ld_addr))),
        .ld_data_i (mem_if.ld_data),
        .st_we_i   (st_we),
        .st_idx_i  (idx_q),
        .st_be_i   (be_q),
        .st_data_i (wdata_q),
        .i_re_i    (mem_if.i_req),
        .i_idx_i   (ADDR_WIDTH'(word_index(mem_if.i_addr))),
        .i_rdata_o (i_word),
        .d_idx_i   (state_q == IDLE ? ADDR_WIDTH'(word_index(mem_if.d_addr)) : idx_q),
        .d_rdata_o (d_word)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            bad_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            i_valid_q <= 1'b0;
            i_ok_q    <= 1'b0;
        end else begin
            i_valid_q <= mem_if.i_req;
            i_ok_q    <= mem_if.i_req && i_ok;
            case (state_q)
                IDLE: begin
                    gnt_q <= !accept;
                    if (accept) begin
                        we_q     <= mem_if.d_we;
                        be_q     <= mem_if.d_be;
                        idx_q    <= ADDR_WIDTH'(word_index(mem_if.d_addr));
                        wdata_q  <= mem_if.d_wdata;
                        bad_q    <= !d_ok;
                        cnt_q    <= CNT_INIT;
                        state_q  <= WAIT_STATES == 0 ? RESP : WAIT;
                        rvalid_q <= WAIT_STATES == 0;
                        err_q    <= WAIT_STATES == 0 && !d_ok;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        err_q    <= bad_q;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    gnt_q    <= 1'b1;
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end
    assign mem_if.d_gnt    = gnt_q;
    assign mem_if.d_rvalid = rvalid_q;
    assign mem_if.d_err    = err_q;
    assign mem_if.d_rdata  = (rvalid_q && !we_q && !err_q) ? d_word : '0;
    assign mem_if.i_valid  = i_valid_q;
    assign mem_if.i_rdata  = i_ok_q ? i_word : '0;
endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb_riscv_mem_responder: directed table, corner sequences and random traffic against a word-array model.
module tb_riscv_mem_responder;
    localparam int AW = 10;
    localparam int W = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    riscv_mem_responder_if #(.DW(32)) bus ();
    riscv_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_STATES(W)) dut (
        .clk(clk), .reset(reset), .mem_if(bus)
    );
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] model [1024];
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       nm;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return a < 32'h1000 && a[1:0] == 2'b00;
`else
        return a < 32'h1000;
`endif
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return addr_ok(a) ? model[a[11:2]] : 32'h0;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        if (addr_ok(a))
            for (int b = 0; b < 4; b++)
                if (be[b]) model[a[11:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        bus.ld_we = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(negedge clk);
        bus.ld_we = 1'b0;
        model[a[11:2]] = d;
    endtask

    task automatic fetch(input logic [31:0] a, input string nm);
        logic [31:0] exp;
        exp = model_rd(a);
        bus.i_req = 1'b1;
        bus.i_addr = a;
        @(negedge clk);
        bus.i_req = 1'b0;
        chk({nm, " i_valid"}, 32'(bus.i_valid), 32'd1);
        chk({nm, " i_rdata"}, bus.i_rdata, exp);
    endtask

    // Leaves the caller at the negedge of the response cycle (or after the cycle budget).
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output bit gnt_bad);
        int t;
        t = 0;
        gnt_bad = 1'b0;
        while (!bus.d_gnt && t < 20) begin
            @(negedge clk);
            t++;
        end
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_be = be;
        bus.d_addr = a;
        bus.d_wdata = wd;
        @(negedge clk);
        bus.d_req = 1'b0;
        lat = 1;
        while (!bus.d_rvalid && lat < 30) begin
            if (bus.d_gnt) gnt_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (bus.d_gnt) gnt_bad = 1'b1;
    endtask

    task automatic access(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string nm);
        int lat;
        bit gb;
        issue(we, be, a, wd, lat, gb);
        chk({nm, " latency"}, 32'(lat), 32'(W + 1));
        chk({nm, " gnt_low"}, 32'(gb), 32'd0);
        chk({nm, " d_err"}, 32'(bus.d_err), 32'(exp_err));
        chk({nm, " d_rdata"}, bus.d_rdata, exp_rd);
        @(negedge clk);
        chk({nm, " pulse"}, 32'(bus.d_rvalid), 32'd0);
    endtask

    task automatic maccess(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                           input string nm);
        logic [31:0] exp_rd;
        exp_rd = (we || !addr_ok(a)) ? 32'h0 : model_rd(a);
        access(we, be, a, wd, exp_rd, !addr_ok(a), nm);
        if (we) model_wr(a, be, wd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen;
        bit gb;
        logic [31:0] old, a;
        bus.ld_we = 0; bus.ld_addr = 0; bus.ld_data = 0;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst i_valid", 32'(bus.i_valid), 32'd0);
        chk("rst i_rdata", bus.i_rdata, 32'd0);
        chk("rst d_gnt", 32'(bus.d_gnt), 32'd0);
        chk("rst d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst d_rdata", bus.d_rdata, 32'd0);
        chk("rst d_err", 32'(bus.d_err), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) preload(32'(i) << 2, $urandom);
        preload(32'h0, 32'h00000013);
        preload(32'h4, 32'h00000013);
        preload(32'h8, 32'hDEADBEEF);
        preload(32'h10, 32'hFFFFFFFF);
        preload(32'h20, 32'h0BADCAFE);
        preload(32'hFFC, 32'h12345678);
        fetch(32'h4, "fetch4");
        chk("fetch4 const", bus.i_rdata, 32'h00000013);
        @(negedge clk);
        chk("i_valid drop", 32'(bus.i_valid), 32'd0);
        fetch(32'h0001_0000, "fetch oor");
        fetch(32'h0000_1000, "fetch end");

        vecs.push_back('{1'b0, 4'h0, 32'h8,        32'h0,        32'hDEADBEEF, 1'b0, "ld 0x8"});
        vecs.push_back('{1'b1, 4'h5, 32'h10,       32'h11223344, 32'h0,        1'b0, "st be5"});
        vecs.push_back('{1'b0, 4'h0, 32'h10,       32'h0,        32'hFF22FF44, 1'b0, "ld merged"});
        vecs.push_back('{1'b0, 4'h0, 32'h00010000, 32'h0,        32'h0,        1'b1, "ld oor"});
        vecs.push_back('{1'b1, 4'hF, 32'h00010000, 32'hAAAAAAAA, 32'h0,        1'b1, "st oor"});
        vecs.push_back('{1'b0, 4'h0, 32'h0,        32'h0,        32'h00000013, 1'b0, "ld 0x0 intact"});
        vecs.push_back('{1'b1, 4'h0, 32'h8,        32'h55555555, 32'h0,        1'b0, "st be0"});
        vecs.push_back('{1'b0, 4'h0, 32'h8,        32'h0,        32'hDEADBEEF, 1'b0, "ld be0 intact"});
        vecs.push_back('{1'b0, 4'h0, 32'hFFC,      32'h0,        32'h12345678, 1'b0, "ld last"});
        vecs.push_back('{1'b0, 4'h0, 32'h1000,     32'h0,        32'h0,        1'b1, "ld past end"});
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back('{1'b1, 4'hF, 32'h22,       32'hA5A50001, 32'h0,        1'b1, "st 0x22"});
        vecs.push_back('{1'b0, 4'h0, 32'h20,       32'h0,        32'h0BADCAFE, 1'b0, "ld 0x20"});
        vecs.push_back('{1'b0, 4'h0, 32'h23,       32'h0,        32'h0,        1'b1, "ld 0x23"});
`else
        vecs.push_back('{1'b1, 4'hF, 32'h22,       32'hA5A50001, 32'h0,        1'b0, "st 0x22"});
        vecs.push_back('{1'b0, 4'h0, 32'h20,       32'h0,        32'hA5A50001, 1'b0, "ld 0x20"});
        vecs.push_back('{1'b0, 4'h0, 32'h23,       32'h0,        32'hA5A50001, 1'b0, "ld 0x23"});
`endif
        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].nm);
            if (vecs[i].we) model_wr(vecs[i].addr, vecs[i].be, vecs[i].wdata);
        end

        while (!bus.d_gnt) @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h20; bus.d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.d_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            if (bus.d_rvalid) seen++;
            @(negedge clk);
        end
        chk("rst drop rvalid", 32'(seen), 32'd0);
        maccess(1'b0, 4'h0, 32'h20, 32'h0, "ld after rst");

        issue(1'b1, 4'hF, 32'h34, 32'h11111111, lat, gb);
        chk("ld collide latency", 32'(lat), 32'(W + 1));
        bus.ld_we = 1'b1; bus.ld_addr = 32'h34; bus.ld_data = 32'h77777777;
        @(negedge clk);
        bus.ld_we = 1'b0;
        model[13] = 32'h77777777;
        maccess(1'b0, 4'h0, 32'h34, 32'h0, "ld wins");

        old = model[14];
        issue(1'b1, 4'hF, 32'h38, 32'h5A5A5A5A, lat, gb);
        chk("i collide latency", 32'(lat), 32'(W + 1));
        bus.i_req = 1'b1; bus.i_addr = 32'h38;
        @(negedge clk);
        bus.i_req = 1'b0;
        chk("i collide valid", 32'(bus.i_valid), 32'd1);
        chk("i collide old", bus.i_rdata, old);
        model_wr(32'h38, 4'hF, 32'h5A5A5A5A);
        maccess(1'b0, 4'h0, 32'h38, 32'h0, "ld after collide");

        for (int i = 0; i < 200; i++) begin
            int r, kind;
            r = $urandom_range(0, 15);
            kind = $urandom_range(0, 3);
            a = 32'($urandom_range(0, 1023)) << 2;
            if (r == 0) a = $urandom | 32'h1000;
            else if (r == 1) a = a | 32'($urandom_range(1, 3));
            if (kind == 0) fetch(a, "rnd fetch");
            else maccess(kind == 1, 4'($urandom), a, $urandom, kind == 1 ? "rnd st" : "rnd ld");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
